// File: rtl/phase_error_detector_pkg.sv
// Shared ADPLL definitions: phase-detector state encoding and error saturation limits.
package phase_error_detector_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRefLead = 2'd1,
    StDcoLead = 2'd2
  } ped_state_e;

  localparam int unsigned ERROR_WIDTH_DEFAULT = 5;

  // Largest error magnitude representable symmetrically in a signed word of this width.
  function automatic int unsigned max_err(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  localparam int unsigned MAXE = max_err(ERROR_WIDTH_DEFAULT);

endpackage

// File: rtl/phase_error_detector_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; flops reset high so an
// input already high at reset release produces no edge.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= async_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign edge_o = r_sync2 & ~r_prev;

endmodule

// File: rtl/phase_error_detector.sv
// Bang-counter phase detector: measures ref/dco edge separation in gen_clk cycles,
// emits a saturated signed error per measurement and tracks lock.
module phase_error_detector
  import phase_error_detector_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH = 5,
  parameter int unsigned HOLD_ERROR  = 0,
  parameter int unsigned LOCK_THRESH = 1,
  parameter int unsigned LOCK_COUNT  = 16
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          ref_clk_i,
  input  logic                          dco_clk_i,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic                          error_valid_o,
  output logic                          lock_o
);

  localparam int unsigned CntW = ERROR_WIDTH - 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(max_err(ERROR_WIDTH));
  localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);

  logic w_ref_edge;
  logic w_dco_edge;

  edge_sync u_ref_sync (
    .clk_i   (gen_clk_i),
    .rst_i   (reset_i),
    .async_i (ref_clk_i),
    .edge_o  (w_ref_edge)
  );

  edge_sync u_dco_sync (
    .clk_i   (gen_clk_i),
    .rst_i   (reset_i),
    .async_i (dco_clk_i),
    .edge_o  (w_dco_edge)
  );

  ped_state_e r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [LockW-1:0] r_lock_cnt, w_lock_cnt_next;
  logic signed [ERROR_WIDTH-1:0] r_err, w_err_val;
  logic r_valid;
  logic r_lock;

  logic            w_emit;
  logic            w_emit_neg;
  logic [CntW-1:0] w_emit_mag;
  logic            w_lead_edge;
  logic            w_close_edge;
  logic [ERROR_WIDTH-1:0] w_mag_ext;
  logic            w_in_lock;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_emit       = 1'b0;
    w_emit_neg   = 1'b0;
    w_emit_mag   = '0;
    w_lead_edge  = (r_state == StDcoLead) ? w_dco_edge : w_ref_edge;
    w_close_edge = (r_state == StDcoLead) ? w_ref_edge : w_dco_edge;

    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_ref_edge && w_dco_edge) begin
          w_emit = 1'b1;
        end else if (w_ref_edge) begin
          w_state_next = StRefLead;
        end else if (w_dco_edge) begin
          w_state_next = StDcoLead;
        end
      end
      StRefLead, StDcoLead: begin
        w_emit_neg = (r_state == StDcoLead);
        // The closing cycle itself counts, hence r_cnt + 1 on a closing edge.
        if (w_close_edge) begin
          w_emit       = 1'b1;
          w_emit_mag   = (r_cnt == MaxCnt) ? MaxCnt : r_cnt + CntW'(1);
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (w_lead_edge) begin
          w_emit     = 1'b1;
          w_emit_mag = MaxCnt;
          w_cnt_next = '0;
        end else if (r_cnt == MaxCnt) begin
          w_emit       = 1'b1;
          w_emit_mag   = MaxCnt;
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_mag_ext = {1'b0, w_emit_mag};
    w_err_val = w_emit_neg ? -$signed(w_mag_ext) : $signed(w_mag_ext);
    w_in_lock = (32'(w_emit_mag) <= LOCK_THRESH);
    if (!w_in_lock) begin
      w_lock_cnt_next = '0;
    end else if (r_lock_cnt == LockW'(LOCK_COUNT)) begin
      w_lock_cnt_next = r_lock_cnt;
    end else begin
      w_lock_cnt_next = r_lock_cnt + LockW'(1);
    end
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_emit;
      if (w_emit) begin
        r_err      <= w_err_val;
        r_lock_cnt <= w_lock_cnt_next;
        r_lock     <= (w_lock_cnt_next == LockW'(LOCK_COUNT));
      end else if (HOLD_ERROR == 0) begin
        r_err <= '0;
      end
    end
  end

  assign error_o       = r_err;
  assign error_valid_o = r_valid;
  assign lock_o        = r_lock;

endmodule

// File: tb/tb_phase_error_detector.sv
// Directed bench for phase_error_detector: lead/lag, coincident edges, timeout, slip,
// lock acquisition/loss and mid-measurement reset.
module tb_phase_error_detector;

  logic              gen_clk;
  logic              reset;
  logic              ref_clk;
  logic              dco_clk;
  logic signed [4:0] error_o;
  logic              error_valid_o;
  logic              lock_o;

  int n_total = 0;
  int n_bad   = 0;

  phase_error_detector #(
    .ERROR_WIDTH (5),
    .HOLD_ERROR  (0),
    .LOCK_THRESH (1),
    .LOCK_COUNT  (16)
  ) dut (
    .gen_clk_i     (gen_clk),
    .reset_i       (reset),
    .ref_clk_i     (ref_clk),
    .dco_clk_i     (dco_clk),
    .error_o       (error_o),
    .error_valid_o (error_valid_o),
    .lock_o        (lock_o)
  );

  initial gen_clk = 1'b0;
  always #5 gen_clk = ~gen_clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_emit(output bit seen, output int err, output int lock);
    seen = 1'b0;
    err  = 0;
    lock = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge gen_clk);
      #1;
      if (error_valid_o) begin
        seen = 1'b1;
        err  = error_o;
        lock = int'(lock_o);
      end
    end
  endtask

  // Waits for one emission, checks value and lock, then checks the strobe is one cycle wide.
  task automatic expect_emit(input string tag, input int exp_err, input int exp_lock);
    bit seen;
    int err;
    int lock;
    wait_emit(seen, err, lock);
    check_eq({tag, "_seen"}, int'(seen), 1);
    if (seen) begin
      check_eq({tag, "_err"}, err, exp_err);
      check_eq({tag, "_lock"}, lock, exp_lock);
      @(posedge gen_clk);
      #1;
      check_eq({tag, "_vld_low"}, int'(error_valid_o), 0);
      check_eq({tag, "_err_zero"}, int'(error_o), 0);
    end
  endtask

  task automatic measure(input string tag, input bit ref_first, input int dly,
                         input int exp_err, input int exp_lock);
    @(negedge gen_clk);
    ref_clk = 1'b0;
    dco_clk = 1'b0;
    repeat (4) @(negedge gen_clk);
    if (dly == 0) begin
      ref_clk = 1'b1;
      dco_clk = 1'b1;
    end else if (ref_first) begin
      ref_clk = 1'b1;
      repeat (dly) @(negedge gen_clk);
      dco_clk = 1'b1;
    end else begin
      dco_clk = 1'b1;
      repeat (dly) @(negedge gen_clk);
      ref_clk = 1'b1;
    end
    expect_emit(tag, exp_err, exp_lock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    reset   = 1'b1;
    ref_clk = 1'b0;
    dco_clk = 1'b0;
    repeat (3) @(negedge gen_clk);
    check_eq("rst_err", int'(error_o), 0);
    check_eq("rst_vld", int'(error_valid_o), 0);
    check_eq("rst_lock", int'(lock_o), 0);
    reset = 1'b0;

    measure("ref_lead3", 1'b1, 3, 3, 0);
    measure("dco_lead5", 1'b0, 5, -5, 0);
    measure("both", 1'b1, 0, 0, 0);
    measure("ref_lead4", 1'b1, 4, 4, 0);

    // Sixteen in-lock measurements, alternating sign; lock rises with the 16th.
    for (int i = 0; i < 16; i++) begin
      measure($sformatf("lock%0d", i), (i % 2) == 0, 1, ((i % 2) == 0) ? 1 : -1,
              (i == 15) ? 1 : 0);
    end
    measure("unlock4", 1'b1, 4, 4, 0);

    // Ref edges roughly every 40 cycles with dco held low: every one times out at +15.
    @(negedge gen_clk);
    ref_clk = 1'b0;
    dco_clk = 1'b0;
    repeat (4) @(negedge gen_clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge gen_clk);
      ref_clk = 1'b1;
      expect_emit($sformatf("tmo%0d", k), 15, 0);
      repeat (3) @(negedge gen_clk);
      ref_clk = 1'b0;
      repeat (18) @(negedge gen_clk);
    end

    // Cycle slip: second ref edge 5 cycles after the first, dco 2 cycles after that.
    ref_clk = 1'b1;
    repeat (2) @(negedge gen_clk);
    ref_clk = 1'b0;
    repeat (3) @(negedge gen_clk);
    ref_clk = 1'b1;
    repeat (2) @(negedge gen_clk);
    dco_clk = 1'b1;
    expect_emit("slip", 15, 0);
    expect_emit("slip_close", 2, 0);

    // Reset two cycles into REF_LEAD with ref held high through release.
    @(negedge gen_clk);
    ref_clk = 1'b0;
    dco_clk = 1'b0;
    repeat (4) @(negedge gen_clk);
    ref_clk = 1'b1;
    repeat (5) @(negedge gen_clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_vld", int'(error_valid_o), 0);
    check_eq("midrst_err", int'(error_o), 0);
    repeat (2) @(negedge gen_clk);
    reset = 1'b0;
    nv = 0;
    repeat (40) begin
      @(posedge gen_clk);
      #1;
      if (error_valid_o) nv++;
    end
    check_eq("midrst_no_emit", nv, 0);
    measure("post_rst", 1'b0, 2, -2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_error_detector.md
PHASE_ERROR_DETECTOR -- requirements
Module: phase_error_detector

Interface
REQ-001 SHALL have parameter ERROR_WIDTH, default 5: signed width of error_o; matches the loop filter error input.
REQ-002 SHALL have parameter HOLD_ERROR, default 0: 1 = hold last error between measurements, 0 = error_o is zero outside the valid cycle.
REQ-003 SHALL have parameter LOCK_THRESH, default 1: maximum |error| counted as in-lock.
REQ-004 SHALL have parameter LOCK_COUNT, default 16: consecutive in-lock measurements required to assert lock_o.
REQ-005 SHALL have port gen_clk_i, input, 1: the single system clock; all state is clocked on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ref_clk_i, input, 1: reference clock, asynchronous to gen_clk_i.
REQ-008 SHALL have port dco_clk_i, input, 1: DCO feedback clock, asynchronous to gen_clk_i.
REQ-009 SHALL have port error_o, output, ERROR_WIDTH, signed: phase error in gen_clk_i cycles; positive = ref leads.
REQ-010 SHALL have port error_valid_o, output, 1: one-cycle strobe marking a new error_o.
REQ-011 SHALL have port lock_o, output, 1: lock indicator.

Function
REQ-012 SHALL pass each of ref_clk_i and dco_clk_i through a 2-flop synchronizer, then a rising-edge detector (edge = sync & ~prev).
REQ-013 SHALL implement a state machine with states IDLE, REF_LEAD and DCO_LEAD, plus an unsigned counter of ERROR_WIDTH-1 bits.
REQ-014 In IDLE:
- ref edge only -> REF_LEAD, counter=0.
- dco edge only -> DCO_LEAD, counter=0.
- both edges in the same cycle -> emit error 0, stay in IDLE.
REQ-015 In REF_LEAD, the counter SHALL increment each cycle; on a dco edge it SHALL emit +counter and return to IDLE.
REQ-016 DCO_LEAD SHALL mirror REF_LEAD, emitting -counter.
REQ-017 Error SHALL saturate at MAXE = 2^(ERROR_WIDTH-1)-1 (15 by default), symmetric: range -MAXE..+MAXE.
REQ-018 Timeout: if counter = MAXE with no closing edge, SHALL emit ±MAXE (sign per state) and return to IDLE.
REQ-019 Cycle slip: a second edge of the leading clock while in REF_LEAD or DCO_LEAD SHALL:
- emit ±MAXE;
- restart the same state with counter=0.
REQ-020 A closing edge and a leading-clock edge in the same cycle SHALL be treated as a closing edge only.
REQ-021 "Emit" SHALL mean: error_o and error_valid_o are registered, and become visible the cycle after the closing edge is detected (latency 1 cycle from detected edge).
REQ-022 With HOLD_ERROR=0, error_o SHALL be 0 whenever error_valid_o=0; with HOLD_ERROR=1 it SHALL hold the last emitted value.
REQ-023 A lock counter SHALL increment on each emission with |error| <= LOCK_THRESH (saturating at LOCK_COUNT), and clear on any other emission.
REQ-024 lock_o SHALL be 1 exactly when the lock counter equals LOCK_COUNT, registered, and updated in the same cycle as error_valid_o.

Reset
REQ-025 Asserting reset_i SHALL immediately force:
- state = IDLE, counter = 0;
- error_o = 0, error_valid_o = 0, lock_o = 0, lock counter = 0.
REQ-026 Synchronizer flops and edge-detector prev flops SHALL reset to 1, so an input already high at reset release produces no edge.
REQ-027 Reset asserted mid-measurement SHALL discard the measurement without any emission.

Structure
REQ-028 State encodings and the MAXE localparam SHALL live in the shared ADPLL defines header used by the other ADPLL blocks.
REQ-029 Synchronizer plus edge detect SHALL be a sub-module edge_sync, instantiated once per input clock.

Verification
REQ-030 With ref rising 3 gen_clk cycles before dco, the bench SHALL see error_o=+3 with a one-cycle error_valid_o.
REQ-031 With dco rising 5 cycles before ref, the bench SHALL see error_o=-5.
REQ-032 With both inputs rising on the same gen_clk edge, the bench SHALL see error_o=0 with valid pulsed.
REQ-033 With ref edges every 40 cycles and dco held low, the bench SHALL see +15 at timeout and then on each ref edge, lock_o=0.
REQ-034 With 16 consecutive measurements of error ±1, the bench SHALL see lock_o rise with the 16th valid; a following error of 4 SHALL drop lock_o.
REQ-035 With reset_i pulsed 2 cycles into REF_LEAD, the bench SHALL see no emission and state IDLE after release; an input held high through release SHALL produce no error.
